// File: rtl/eda_regional_max_ctrl.sv
// Frame sequencer for the eda_regional_max core: loads an MxN frame into core memory in
// raster order, then scans every pixel as window centre and streams one max flag per pixel.
module eda_regional_max_ctrl #(
    parameter int M           = 6,
    parameter int N           = 6,
    parameter int PIXEL_WIDTH = 8,
    parameter int I_WIDTH     = $clog2(M),
    parameter int J_WIDTH     = $clog2(N),
    parameter int ADDR_WIDTH  = I_WIDTH + J_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [PIXEL_WIDTH-1:0] s_pixel,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [ADDR_WIDTH-1:0]  m_addr,
    output logic                   m_is_max,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   write_en,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [PIXEL_WIDTH-1:0] pixel_in,
    output logic [ADDR_WIDTH-1:0]  center_addr,
    output logic                   new_pixel,
    output logic                   clear,
    input  logic                   core_done,
    input  logic                   core_is_max,
    output logic [2:0]             dbg_state
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLR    = 3'd1;
    localparam logic [2:0] ST_LOAD   = 3'd2;
    localparam logic [2:0] ST_ISSUE  = 3'd3;
    localparam logic [2:0] ST_WAIT   = 3'd4;
    localparam logic [2:0] ST_RESULT = 3'd5;
    localparam logic [2:0] ST_FIN    = 3'd6;
    localparam logic [2:0] ST_ACLR   = 3'd7;

    localparam logic [I_WIDTH-1:0] I_LAST = I_WIDTH'(M - 1);
    localparam logic [J_WIDTH-1:0] J_LAST = J_WIDTH'(N - 1);

    logic [2:0]             state_q, state_d;
    logic [I_WIDTH-1:0]     i_q, i_d;
    logic [J_WIDTH-1:0]     j_q, j_d;
    logic                   write_en_q, new_pixel_q, clear_q, m_valid_q, frame_done_q;
    logic                   m_is_max_q;
    logic [ADDR_WIDTH-1:0]  wr_addr_q, center_addr_q, m_addr_q;
    logic [PIXEL_WIDTH-1:0] pixel_in_q;
    logic                   beat, last_px, abort_hit, advance;

    // Valid/ready on both streams: a transfer happens on a rising edge where valid and
    // ready are both high; the producer holds valid and payload stable until that edge.
    assign s_ready   = (state_q == ST_LOAD);
    assign busy      = (state_q != ST_IDLE);
    assign beat      = s_ready && s_valid;
    assign last_px   = (i_q == I_LAST) && (j_q == J_LAST);
    assign abort_hit = abort && (state_q != ST_IDLE);
    assign advance   = beat || ((state_q == ST_RESULT) && m_ready);

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        if (state_q == ST_CLR) begin
            i_d = '0;
            j_d = '0;
        end else if (advance) begin
            if (j_q == J_LAST) begin
                j_d = '0;
                i_d = (i_q == I_LAST) ? '0 : i_q + I_WIDTH'(1);
            end else begin
                j_d = j_q + J_WIDTH'(1);
            end
        end

        case (state_q)
            ST_IDLE:   if (start) state_d = ST_CLR;
            ST_CLR:    state_d = ST_LOAD;
            ST_LOAD:   if (beat && last_px) state_d = ST_ISSUE;
            ST_ISSUE:  state_d = ST_WAIT;
            ST_WAIT:   if (core_done) state_d = ST_RESULT;
            ST_RESULT: if (m_ready) state_d = last_px ? ST_FIN : ST_ISSUE;
            ST_FIN:    state_d = ST_IDLE;
            ST_ACLR:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // The CLR cycle already carries a clear pulse, so aborting there needs no second one.
        if (abort_hit && state_q != ST_ACLR) begin
            state_d = (state_q == ST_CLR) ? ST_IDLE : ST_ACLR;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            i_q           <= '0;
            j_q           <= '0;
            write_en_q    <= 1'b0;
            new_pixel_q   <= 1'b0;
            clear_q       <= 1'b0;
            m_valid_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            m_is_max_q    <= 1'b0;
            wr_addr_q     <= '0;
            center_addr_q <= '0;
            m_addr_q      <= '0;
            pixel_in_q    <= '0;
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            j_q          <= j_d;
            clear_q      <= (state_d == ST_CLR) || (state_d == ST_ACLR);
            frame_done_q <= (state_d == ST_FIN);
            write_en_q   <= beat && !abort;
            if (beat) begin
                wr_addr_q  <= {i_q, j_q};
                pixel_in_q <= s_pixel;
            end
            // new_pixel lands one cycle after ISSUE so the last memory write precedes it.
            new_pixel_q <= (state_q == ST_ISSUE) && !abort;
            if (state_q == ST_ISSUE) center_addr_q <= {i_q, j_q};
            if (state_q == ST_WAIT && core_done && !abort) begin
                m_valid_q  <= 1'b1;
                m_addr_q   <= center_addr_q;
                m_is_max_q <= core_is_max;
            end else if (abort_hit || (state_q == ST_RESULT && m_ready)) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign write_en    = write_en_q;
    assign wr_addr     = wr_addr_q;
    assign pixel_in    = pixel_in_q;
    assign center_addr = center_addr_q;
    assign new_pixel   = new_pixel_q;
    assign clear       = clear_q;
    assign m_valid     = m_valid_q;
    assign m_addr      = m_addr_q;
    assign m_is_max    = m_is_max_q;
    assign frame_done  = frame_done_q;
    assign dbg_state   = state_q;

endmodule
